// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and read-owner encoding.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arb_prio.sv
// Priority and starvation logic: CPU wins by default, loader wins once it has lost MAX_WAIT cycles in a row.
module dmem_arb_prio import dmem_pkg::*; #(
  parameter int MAX_WAIT = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic CpuReq,
  input  logic LdrReq,
  output logic CpuGnt,
  output logic LdrGnt
);

  logic [7:0] waitCnt;
  logic       ldrWins;

  // Grants are gated by reset so nothing reaches the BRAM while Rst_n is low
  always_comb begin
    ldrWins = LdrReq & (~CpuReq | (waitCnt == 8'(MAX_WAIT)));
    LdrGnt  = Rst_n & ldrWins;
    CpuGnt  = Rst_n & CpuReq & ~ldrWins;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      waitCnt <= '0;
    end else if (LdrGnt || !LdrReq) begin
      waitCnt <= '0;
    end else if (waitCnt != 8'(MAX_WAIT)) begin
      waitCnt <= waitCnt + 8'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data BRAM between the CPU and the loader port.
// Optional access/conflict counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter import dmem_pkg::*; #(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuDin,
  output logic              CpuGnt,
  output logic              CpuStall,
  output logic              CpuRdValid,
  output logic [DATA_W-1:0] CpuDout,
  input  logic              LdrReq,
  input  logic              LdrWe,
  input  logic [ADDR_W-1:0] LdrAddr,
  input  logic [DATA_W-1:0] LdrDin,
  output logic              LdrGnt,
  output logic              LdrRdValid,
  output logic [DATA_W-1:0] LdrDout,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       CpuAccCnt,
  output logic [15:0]       LdrAccCnt,
  output logic [15:0]       ConflictCnt,
`endif
  output logic              MemEna,
  output logic              MemWea,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDin,
  input  logic [DATA_W-1:0] MemDout
);

  owner_e owner;

  dmem_arb_prio #(.MAX_WAIT(MAX_WAIT)) uPrio (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .CpuReq (CpuReq),
    .LdrReq (LdrReq),
    .CpuGnt (CpuGnt),
    .LdrGnt (LdrGnt)
  );

  // With no grant the CPU side stays on the address/data bus so it never floats
  always_comb begin
    MemEna   = CpuGnt | LdrGnt;
    MemWea   = (CpuGnt & CpuWe) | (LdrGnt & LdrWe);
    MemAddr  = LdrGnt ? LdrAddr : CpuAddr;
    MemDin   = LdrGnt ? LdrDin  : CpuDin;
    CpuStall = CpuReq & ~CpuGnt;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      owner <= OWN_NONE;
    end else if (CpuGnt && !CpuWe) begin
      owner <= OWN_CPU;
    end else if (LdrGnt && !LdrWe) begin
      owner <= OWN_LDR;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign CpuRdValid = (owner == OWN_CPU);
  assign LdrRdValid = (owner == OWN_LDR);
  assign CpuDout    = MemDout;
  assign LdrDout    = MemDout;

`ifdef DMEM_ARB_STATS_EN
  // Counters wrap naturally at 16 bits
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      CpuAccCnt   <= '0;
      LdrAccCnt   <= '0;
      ConflictCnt <= '0;
    end else begin
      if (CpuGnt)           CpuAccCnt   <= CpuAccCnt + 16'd1;
      if (LdrGnt)           LdrAccCnt   <= LdrAccCnt + 16'd1;
      if (CpuReq && LdrReq) ConflictCnt <= ConflictCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency BRAM model.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        CpuReq, CpuWe, LdrReq, LdrWe;
  logic [11:0] CpuAddr, LdrAddr;
  logic [31:0] CpuDin, LdrDin;
  logic        CpuGnt, CpuStall, CpuRdValid, LdrGnt, LdrRdValid;
  logic [31:0] CpuDout, LdrDout;
  logic        MemEna, MemWea;
  logic [11:0] MemAddr;
  logic [31:0] MemDin;
  logic [31:0] MemDout;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] CpuAccCnt, LdrAccCnt, ConflictCnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];

  always #5 Clk = ~Clk;

  // BRAM model: read-before-write, data one cycle after enable
  always @(posedge Clk) begin
    if (MemEna) begin
      if (MemWea) mem[MemAddr] <= MemDin;
      MemDout <= mem[MemAddr];
    end
  end

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(4)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .CpuReq     (CpuReq),
    .CpuWe      (CpuWe),
    .CpuAddr    (CpuAddr),
    .CpuDin     (CpuDin),
    .CpuGnt     (CpuGnt),
    .CpuStall   (CpuStall),
    .CpuRdValid (CpuRdValid),
    .CpuDout    (CpuDout),
    .LdrReq     (LdrReq),
    .LdrWe      (LdrWe),
    .LdrAddr    (LdrAddr),
    .LdrDin     (LdrDin),
    .LdrGnt     (LdrGnt),
    .LdrRdValid (LdrRdValid),
    .LdrDout    (LdrDout),
`ifdef DMEM_ARB_STATS_EN
    .CpuAccCnt  (CpuAccCnt),
    .LdrAccCnt  (LdrAccCnt),
    .ConflictCnt(ConflictCnt),
`endif
    .MemEna     (MemEna),
    .MemWea     (MemWea),
    .MemAddr    (MemAddr),
    .MemDin     (MemDin),
    .MemDout    (MemDout)
  );

  task automatic applyStimulus();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    Rst_n = 1'b0;
    CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 12'h010; CpuDin = '0;
    LdrReq = 1'b1; LdrWe = 1'b0; LdrAddr = 12'h030; LdrDin = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_memena", 32'(MemEna), 32'd0);
    checkOutput("rst_cpugnt", 32'(CpuGnt), 32'd0);
    checkOutput("rst_ldrgnt", 32'(LdrGnt), 32'd0);
    checkOutput("rst_cpurdv", 32'(CpuRdValid), 32'd0);
    checkOutput("rst_ldrrdv", 32'(LdrRdValid), 32'd0);
    checkOutput("rst_cpustall", 32'(CpuStall), 32'd1);

    Rst_n = 1'b1;
    #1;
    checkOutput("rel_cpugnt", 32'(CpuGnt), 32'd1);
    checkOutput("rel_ldrgnt", 32'(LdrGnt), 32'd0);

    // Preload through the loader port
    applyStimulus();
    CpuReq = 1'b0;
    LdrReq = 1'b1; LdrWe = 1'b1; LdrAddr = 12'h010; LdrDin = 32'hDEADBEEF;
    #1;
    checkOutput("pre1_ldrgnt", 32'(LdrGnt), 32'd1);
    applyStimulus();
    LdrAddr = 12'h030; LdrDin = 32'hCAFEF00D;
    applyStimulus();
    LdrReq = 1'b0; LdrWe = 1'b0;

    // CPU read alone
    CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 12'h010;
    #1;
    checkOutput("rd_cpugnt", 32'(CpuGnt), 32'd1);
    checkOutput("rd_memaddr", 32'(MemAddr), 32'h010);
    checkOutput("rd_memwea", 32'(MemWea), 32'd0);
    applyStimulus();
    CpuReq = 1'b0;
    checkOutput("rd_cpurdv", 32'(CpuRdValid), 32'd1);
    checkOutput("rd_cpudout", CpuDout, 32'hDEADBEEF);
    checkOutput("rd_ldrrdv", 32'(LdrRdValid), 32'd0);

    // Loader write then CPU read of the same word
    LdrReq = 1'b1; LdrWe = 1'b1; LdrAddr = 12'h020; LdrDin = 32'h12345678;
    #1;
    checkOutput("wr_ldrgnt", 32'(LdrGnt), 32'd1);
    checkOutput("wr_memwea", 32'(MemWea), 32'd1);
    checkOutput("wr_memaddr", 32'(MemAddr), 32'h020);
    checkOutput("wr_memdin", MemDin, 32'h12345678);
    applyStimulus();
    LdrReq = 1'b0; LdrWe = 1'b0;
    CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 12'h020;
    #1;
    checkOutput("raw_cpugnt", 32'(CpuGnt), 32'd1);
    checkOutput("raw_ldrrdv", 32'(LdrRdValid), 32'd0);
    applyStimulus();
    CpuReq = 1'b0;
    checkOutput("raw_cpurdv", 32'(CpuRdValid), 32'd1);
    checkOutput("raw_cpudout", CpuDout, 32'h12345678);

    // Starvation bound: loader wins exactly at cycle 4
    CpuReq = 1'b1; CpuAddr = 12'h010;
    LdrReq = 1'b1; LdrWe = 1'b0; LdrAddr = 12'h030;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("starve_cpugnt_c%0d", i), 32'(CpuGnt), 32'd1);
      checkOutput($sformatf("starve_ldrgnt_c%0d", i), 32'(LdrGnt), 32'd0);
      applyStimulus();
    end
    checkOutput("starve_ldrgnt_c4", 32'(LdrGnt), 32'd1);
    checkOutput("starve_cpustall_c4", 32'(CpuStall), 32'd1);
    checkOutput("starve_memaddr_c4", 32'(MemAddr), 32'h030);
    applyStimulus();
    checkOutput("starve_cpugnt_c5", 32'(CpuGnt), 32'd1);
    checkOutput("starve_ldrgnt_c5", 32'(LdrGnt), 32'd0);
    checkOutput("starve_ldrrdv_c5", 32'(LdrRdValid), 32'd1);
    checkOutput("starve_ldrdout_c5", LdrDout, 32'hCAFEF00D);
    applyStimulus();
    CpuReq = 1'b0; LdrReq = 1'b0;
    checkOutput("starve_cpurdv_c6", 32'(CpuRdValid), 32'd1);
    applyStimulus();

    // Alternating reads: CPU A then loader B, no bubble
    CpuReq = 1'b1; CpuAddr = 12'h010;
    applyStimulus();
    CpuReq = 1'b0;
    LdrReq = 1'b1; LdrAddr = 12'h030;
    #1;
    checkOutput("alt_ldrgnt", 32'(LdrGnt), 32'd1);
    checkOutput("alt_cpurdv1", 32'(CpuRdValid), 32'd1);
    checkOutput("alt_cpudout1", CpuDout, 32'hDEADBEEF);
    checkOutput("alt_ldrrdv1", 32'(LdrRdValid), 32'd0);
    applyStimulus();
    LdrReq = 1'b0;
    checkOutput("alt_ldrrdv2", 32'(LdrRdValid), 32'd1);
    checkOutput("alt_ldrdout2", LdrDout, 32'hCAFEF00D);
    checkOutput("alt_cpurdv2", 32'(CpuRdValid), 32'd0);
    applyStimulus();

    // Mid-operation reset after the loader has accumulated wait cycles
    CpuReq = 1'b1; CpuAddr = 12'h010;
    LdrReq = 1'b1; LdrAddr = 12'h030;
    applyStimulus();
    applyStimulus();
    checkOutput("mid_cpugnt", 32'(CpuGnt), 32'd1);
    #7;
    Rst_n = 1'b0;
    applyStimulus();
    checkOutput("mid_cpurdv", 32'(CpuRdValid), 32'd0);
    checkOutput("mid_memena", 32'(MemEna), 32'd0);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("mid_cpuacc", 32'(CpuAccCnt), 32'd0);
    checkOutput("mid_ldracc", 32'(LdrAccCnt), 32'd0);
    checkOutput("mid_conflict", 32'(ConflictCnt), 32'd0);
`endif
    Rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("postrst_cpugnt_c%0d", i), 32'(CpuGnt), 32'd1);
      applyStimulus();
    end
    checkOutput("postrst_ldrgnt_c4", 32'(LdrGnt), 32'd1);
    applyStimulus();
    CpuReq = 1'b0; LdrReq = 1'b0;
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
